// File: rtl/alu_commit_stage.sv
// ALU result commit stage: 2-entry skid buffer toward the register file,
// architectural PSR with per-instruction flag masks, and branch condition evaluation.
module alu_commit_stage #(
  parameter int DATAWIDTH = 16,
  parameter int REGWIDTH  = 4,
  parameter int PSRWIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_result,
  input  logic [PSRWIDTH-1:0]  in_flags,
  input  logic [PSRWIDTH-1:0]  in_flagMask,
  input  logic                 in_wrEn,
  input  logic [REGWIDTH-1:0]  in_wrAddr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_result,
  output logic                 out_wrEn,
  output logic [REGWIDTH-1:0]  out_wrAddr,
  input  logic                 flush,
  input  logic                 psrWe,
  input  logic [PSRWIDTH-1:0]  psrWData,
  output logic [PSRWIDTH-1:0]  psr,
  input  logic [3:0]           cond,
  output logic                 condTrue
);

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [DATAWIDTH-1:0] result;
    logic [PSRWIDTH-1:0]  flags;
    logic [PSRWIDTH-1:0]  mask;
    logic                 wrEn;
    logic [REGWIDTH-1:0]  wrAddr;
  } entry_t;

  state_t                state_q, state_d;
  logic                  in_ready_q;
  entry_t                head_q, head_d;
  entry_t                skid_q;
  entry_t                in_entry;
  logic [PSRWIDTH-1:0]   psr_q, psr_d;
  logic                  accept, commit;
  logic                  load_head_in, load_head_skid, load_skid;

  assign in_entry = '{result: in_result, flags: in_flags, mask: in_flagMask,
                      wrEn: in_wrEn, wrAddr: in_wrAddr};

  assign accept     = in_valid & in_ready_q;
  assign commit     = out_valid & out_ready;
  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = head_q.result;
  assign out_wrEn   = head_q.wrEn;
  assign out_wrAddr = head_q.wrAddr;
  assign psr        = psr_q;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d      = ONE;
        load_head_in = 1'b1;
      end
      ONE: begin
        if (accept && !commit) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (commit && !accept) begin
          state_d = EMPTY;
        end else if (accept && commit) begin
          load_head_in = 1'b1;
        end
      end
      FULL: if (commit) begin
        state_d        = ONE;
        load_head_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything uncommitted, including a same-cycle accept.
    if (flush) begin
      state_d        = EMPTY;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_comb begin
    head_d = head_q;
    if (load_head_in)        head_d = in_entry;
    else if (load_head_skid) head_d = skid_q;
  end

  // An explicit PSR write overrides both commit flags and flush.
  always_comb begin
    psr_d = psr_q;
    if (psrWe)                 psr_d = psrWData;
    else if (commit && !flush) psr_d = (psr_q & ~head_q.mask) | (head_q.flags & head_q.mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      psr_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      head_q     <= head_d;
      psr_q      <= psr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_entry;
  end

  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'h0: condTrue =  psr_q[PSR_Z];
      4'h1: condTrue = !psr_q[PSR_Z];
      4'h2: condTrue =  psr_q[PSR_C];
      4'h3: condTrue = !psr_q[PSR_C];
      4'h4: condTrue =  psr_q[PSR_L];
      4'h5: condTrue = !psr_q[PSR_L];
      4'h6: condTrue =  psr_q[PSR_N];
      4'h7: condTrue = !psr_q[PSR_N];
      4'h8: condTrue =  psr_q[PSR_F];
      4'h9: condTrue = !psr_q[PSR_F];
      4'hA: condTrue = !psr_q[PSR_L] && !psr_q[PSR_Z];
      4'hB: condTrue =  psr_q[PSR_L] ||  psr_q[PSR_Z];
      4'hC: condTrue = !psr_q[PSR_N] && !psr_q[PSR_Z];
      4'hD: condTrue =  psr_q[PSR_N] ||  psr_q[PSR_Z];
      4'hE: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_commit_stage.sv
// Bench for alu_commit_stage: scoreboard of accepted entries checked at commit,
// a condition-code vector table, and hand-written multi-cycle corner sequences.
module tb_alu_commit_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [15:0] in_result;
  logic [4:0]  in_flags, in_flagMask;
  logic        in_wrEn;
  logic [3:0]  in_wrAddr;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_wrEn;
  logic [3:0]  out_wrAddr;
  logic        flush, psrWe;
  logic [4:0]  psrWData, psr;
  logic [3:0]  cond;
  logic        condTrue;

  always #5 clk = ~clk;

  alu_commit_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_flagMask(in_flagMask), .in_wrEn(in_wrEn), .in_wrAddr(in_wrAddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wrEn(out_wrEn), .out_wrAddr(out_wrAddr),
    .flush(flush), .psrWe(psrWe), .psrWData(psrWData), .psr(psr),
    .cond(cond), .condTrue(condTrue)
  );

  typedef struct {
    logic [15:0] result;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [4:0]  flags;
    logic [4:0]  mask;
  } exp_t;

  typedef struct {
    logic [4:0] psr;
    logic [3:0] cond;
    logic       exp;
  } cc_vec_t;

  exp_t       sb[$];
  logic [4:0] exp_psr;
  int         total = 0;
  int         bad   = 0;
  bit         last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] r, input logic [4:0] f,
                        input logic [4:0] m, input logic we, input logic [3:0] a);
    in_valid = v; in_result = r; in_flags = f; in_flagMask = m; in_wrEn = we; in_wrAddr = a;
  endtask

  // One clock cycle: inputs are already applied; checks, updates model, ends at next negedge.
  task automatic cycle();
    bit   acc, com;
    exp_t e;
    #1;
    chk("in_ready", in_ready, sb.size() < 2);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("psr", psr, exp_psr);
    acc = in_valid && (sb.size() < 2);
    com = (sb.size() != 0) && out_ready;
    if (com) begin
      e = sb.pop_front();
      chk("out_result", out_result, e.result);
      chk("out_wrEn", out_wrEn, e.wrEn);
      chk("out_wrAddr", out_wrAddr, e.wrAddr);
      if (!psrWe && !flush) exp_psr = (exp_psr & ~e.mask) | (e.flags & e.mask);
    end
    if (psrWe) exp_psr = psrWData;
    last_acc = acc && !flush;
    if (flush) sb.delete();
    else if (acc) sb.push_back('{in_result, in_wrEn, in_wrAddr, in_flags, in_flagMask});
    @(negedge clk);
  endtask

  cc_vec_t cc_tab[$];
  int      delay;

  initial begin
    reset_n = 1'b0; out_ready = 1'b0; flush = 1'b0; psrWe = 1'b0; psrWData = '0; cond = '0;
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0);
    exp_psr = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_wrEn", out_wrEn, 0);
    chk("rst_out_wrAddr", out_wrAddr, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_psr", psr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 16'(i), 5'h1F, 5'h0, 1'b1, 4'(i));
      cycle();
      chk("stream_accept", last_acc, 1);
    end
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0);
    repeat (2) cycle();

    // Backpressure: A, B fill the buffer, C waits for room
    out_ready = 1'b0;
    set_in(1'b1, 16'hAAAA, 5'h0, 5'h0, 1'b1, 4'hA); cycle();
    set_in(1'b1, 16'hBBBB, 5'h0, 5'h0, 1'b0, 4'hB); cycle();
    set_in(1'b1, 16'hCCCC, 5'h0, 5'h0, 1'b1, 4'hC); cycle();
    chk("bp_c_held", last_acc, 0);
    cycle();
    chk("bp_c_held2", last_acc, 0);
    out_ready = 1'b1;
    delay = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_acc) begin delay = i; break; end
    end
    chk("bp_c_accept_delay", delay, 1);
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0);
    repeat (3) cycle();
    chk("bp_drained", sb.size(), 0);

    // Flag mask latching
    psrWe = 1'b1; psrWData = 5'h00; cycle(); psrWe = 1'b0;
    set_in(1'b1, 16'h1234, 5'h1F, 5'b01001, 1'b0, 4'h1); cycle();
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0); cycle();
    chk("mask_zc", psr, 5'b01001);
    set_in(1'b1, 16'h5678, 5'h1F, 5'b00000, 1'b1, 4'h2); cycle();
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0); cycle();
    chk("mask_zero", psr, 5'b01001);

    // psrWe beats a same-cycle commit
    out_ready = 1'b0;
    set_in(1'b1, 16'h0F0F, 5'h1F, 5'h1F, 1'b1, 4'h3); cycle();
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0);
    out_ready = 1'b1; psrWe = 1'b1; psrWData = 5'h00; cycle();
    psrWe = 1'b0;
    chk("prio_psrwe", psr, 5'h00);

    // Flush beats a same-cycle commit and drops a same-cycle accept
    psrWe = 1'b1; psrWData = 5'b00110; cycle(); psrWe = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 16'h7777, 5'b11001, 5'h1F, 1'b1, 4'h7); cycle();
    set_in(1'b1, 16'h8888, 5'h1F, 5'h1F, 1'b1, 4'h8);
    out_ready = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0;
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0);
    chk("flush_psr", psr, 5'b00110);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    cycle();

    // Asynchronous reset while FULL
    psrWe = 1'b1; psrWData = 5'b10101; cycle(); psrWe = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 16'h1111, 5'h0, 5'h0, 1'b1, 4'h1); cycle();
    set_in(1'b1, 16'h2222, 5'h0, 5'h0, 1'b1, 4'h2); cycle();
    set_in(1'b0, 16'h0, 5'h0, 5'h0, 1'b0, 4'h0);
    chk("pre_rst_full", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_psr", psr, 0);
    sb.delete(); exp_psr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Condition codes against psr (C=0 L=1 F=2 Z=3 N=4)
    cc_tab = '{
      '{5'b01000, 4'h0, 1'b1}, '{5'b01000, 4'h1, 1'b0}, '{5'b01000, 4'hB, 1'b1},
      '{5'b01000, 4'hA, 1'b0}, '{5'b01000, 4'hD, 1'b1}, '{5'b01000, 4'hC, 1'b0},
      '{5'b00000, 4'hA, 1'b1}, '{5'b00000, 4'hC, 1'b1}, '{5'b00000, 4'hE, 1'b1},
      '{5'b00000, 4'hF, 1'b0}, '{5'b00000, 4'h0, 1'b0}, '{5'b00000, 4'h3, 1'b1},
      '{5'b00001, 4'h2, 1'b1}, '{5'b00001, 4'h3, 1'b0}, '{5'b00010, 4'h4, 1'b1},
      '{5'b00010, 4'h5, 1'b0}, '{5'b00010, 4'hA, 1'b0}, '{5'b00100, 4'h8, 1'b1},
      '{5'b00100, 4'h9, 1'b0}, '{5'b10000, 4'h6, 1'b1}, '{5'b10000, 4'h7, 1'b0},
      '{5'b10000, 4'hC, 1'b0}, '{5'b10000, 4'hD, 1'b1}, '{5'b11111, 4'hF, 1'b0}
    };
    foreach (cc_tab[i]) begin
      psrWe = 1'b1; psrWData = cc_tab[i].psr; cycle(); psrWe = 1'b0;
      cond = cc_tab[i].cond;
      #1;
      chk($sformatf("cond_%0h_psr_%b", cc_tab[i].cond, cc_tab[i].psr), condTrue, cc_tab[i].exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
